// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-to-decode push handshake carrying raw instruction and PC
interface decode_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_raw;
  logic [31:0] pc_in;
  modport master (output in_valid, instr_raw, pc_in, input in_ready);
  modport slave  (input in_valid, instr_raw, pc_in, output in_ready);
endinterface

// File: rtl/decode_queue.sv
// decode_queue: RV32I(+M) decode stage fed by a DEPTH-entry fetch queue, with JALR bubbles
module decode_queue #(
  parameter int DEPTH        = 4,
  parameter int JALR_BUBBLES = 1,
  parameter int EN_MUL       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  decode_queue_if.slave          f,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [31:0]            imm,
  output logic [31:0]            jalr_imm,
  output logic [31:0]            pc_out,
  output logic [4:0]             ctl,
  output logic                   src_imm,
  output logic                   src_pc,
  output logic                   read_reg1,
  output logic                   read_reg2,
  output logic                   reg_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [4:0]             reg1_addr,
  output logic [4:0]             reg2_addr,
  output logic [4:0]             write_reg,
  output logic [5:0]             br,
  output logic                   data_in,
  output logic                   data_out,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic        ov;
    logic [31:0] imm;
    logic [31:0] jimm;
    logic [31:0] pc;
    logic [4:0]  ctl;
    logic        sim;
    logic        spc;
    logic        rr1;
    logic        rr2;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [5:0]  br;
    logic        din;
    logic        dout;
    logic        ill;
  } bundle_t;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [2:0]    bcnt, bi;
  logic [31:0]   hi, hpc;
  logic [6:0]    op, f7;
  logic [2:0]    f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_lw, is_sw, is_opi, is_op, is_din, is_dout;
  logic opi_ok, op_ok, alt, bad, push, pop, jalr_go, drop;
  bundle_t d, q;
  function automatic logic [4:0] alu(input logic [2:0] s, input logic a);
    return (s == 3'd0) ? (a ? 5'd6 : 5'd2) : (s == 3'd1) ? 5'd4 : (s == 3'd2) ? 5'd7 :
           (s == 3'd3) ? 5'd13 : (s == 3'd4) ? 5'd3 : (s == 3'd5) ? (a ? 5'd15 : 5'd5) :
           (s == 3'd6) ? 5'd1 : 5'd0;
  endfunction
  assign {hi, hpc} = mem[rp];
  assign op = hi[6:0];
  assign f3 = hi[14:12];
  assign f7 = hi[31:25];
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111 && f3 == 3'b000;
  assign is_br    = op == 7'b1100011 && f3[2:1] != 2'b01;
  assign is_lw    = op == 7'b0000011 && f3 == 3'b010;
  assign is_sw    = op == 7'b0100011 && f3 == 3'b010;
  assign is_opi   = op == 7'b0010011;
  assign is_op    = op == 7'b0110011;
  assign is_din   = op == 7'b0000000;
  assign is_dout  = op == 7'b0000001;
  assign opi_ok = (f3 == 3'b001) ? f7 == 7'h00 : (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
  assign op_ok  = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) ||
                  (f7 == 7'h01 && EN_MUL != 0);
  assign bad = !(is_lui || is_auipc || is_jal || is_jalr || is_br || is_lw || is_sw ||
                 (is_opi && opi_ok) || (is_op && op_ok) || is_din || is_dout);
  // sub/sra select only on R-type or the shift-right immediate form
  assign alt = f7[5] && (is_op || f3 == 3'b101);
  assign bi  = f3[2] ? 3'd2 + {1'b0, f3[1:0]} : {2'b00, f3[0]};
  always_comb begin
    d      = '0;
    d.ov   = 1'b1;
    d.ill  = bad;
    d.ctl  = bad ? 5'd31 : (is_op && f7 == 7'h01) ? {2'b10, f3} : (is_op || is_opi) ? alu(f3, alt) :
             is_lui ? 5'd10 : (is_lw || is_sw || is_auipc || is_jal || is_jalr) ? 5'd2 : 5'd31;
    d.imm  = (is_jal || is_jalr) ? 32'd4 : (is_opi || is_lw) ? {{20{hi[31]}}, hi[31:20]} :
             is_sw ? {{20{hi[31]}}, hi[31:25], hi[11:7]} :
             (is_lui || is_auipc) ? {hi[31:12], 12'd0} : 32'd0;
    d.jimm = {{20{hi[31]}}, hi[31:20]};
    d.pc   = hpc;
    d.sim  = !is_op;
    d.spc  = is_auipc || is_jal || is_jalr;
    d.rr1  = !(is_lui || is_auipc || is_jal);
    d.rr2  = is_op || is_sw || is_br;
    d.rw   = !(is_br || is_sw || is_dout || bad);
    d.mr   = is_lw;
    d.mw   = is_sw;
    d.r1   = hi[19:15];
    d.r2   = hi[24:20];
    d.wr   = hi[11:7];
    d.br   = is_br ? 6'b000001 << bi : 6'b000000;
    d.din  = is_din;
    d.dout = is_dout;
  end
  assign pop     = !flush && !stall && bcnt == 3'd0 && count != '0;
  assign jalr_go = pop && is_jalr;
  assign drop    = flush || bcnt != 3'd0 || jalr_go;
  assign f.in_ready = count != (AW + 1)'(DEPTH);
  assign push    = f.in_valid && f.in_ready && !drop;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {f.instr_raw, f.pc_in};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      bcnt  <= 3'd0;
      q     <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      // a flush or an issued JALR discards every queued entry
      rp    <= (flush || jalr_go) ? wp : rp + AW'(pop);
      count <= (flush || jalr_go) ? '0 : count + (AW + 1)'(push) - (AW + 1)'(pop);
      if (flush) begin
        q    <= '0;
        bcnt <= 3'd0;
      end else if (!stall) begin
        q    <= pop ? d : '0;
        bcnt <= (bcnt != 3'd0) ? bcnt - 3'd1 : jalr_go ? 3'(JALR_BUBBLES) : 3'd0;
      end
    end
  assign {out_valid, imm, jalr_imm, pc_out, ctl, src_imm, src_pc, read_reg1, read_reg2, reg_write,
          mem_read, mem_write, reg1_addr, reg2_addr, write_reg, br, data_in, data_out, illegal} = q;
endmodule
